// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice per stage, with the
// inter-slice carry registered, a global-stall valid/ready pipeline and signed overflow.
module pipe_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;
    // Stage k keeps (k+1)*CHUNK result bits and WIDTH-(k+1)*CHUNK bits of each
    // pending operand; both are packed back to back so no register bit is idle.
    localparam int RES_W   = CHUNK * STAGES * (STAGES + 1) / 2;
    localparam int OP_USED = (STAGES - 1) * WIDTH - CHUNK * (STAGES - 1) * STAGES / 2;
    localparam int OP_W    = (OP_USED > 0) ? OP_USED : 1;

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] cy_q, cy_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic [OP_W-1:0]   opa_q, opa_d;
    logic [OP_W-1:0]   opb_q, opb_d;
    logic              ovf_q, ovf_d;

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // Handshake: a bundle transfers on a rising edge where valid & ready are both 1.
    // The whole pipe advances together whenever the last slot is empty or being
    // consumed, so in_ready depends only on out_ready and the last valid bit.
    assign en       = ~v_q[STAGES-1] | out_ready;
    assign in_ready = en;

    assign b_eff = sub ? ~b : b;
    assign c_eff = sub | c_in;

    always_comb begin
        v_d    = '0;
        v_d[0] = in_valid;
        for (int i = 1; i < STAGES; i++) begin
            v_d[i] = v_q[i-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int RO  = CHUNK * k * (k + 1) / 2;
        localparam int OO  = k * WIDTH - RO;
        localparam int REM = WIDTH - (k + 1) * CHUNK;

        logic [CHUNK-1:0] sa;
        logic [CHUNK-1:0] sb;
        logic             ci;
        logic [CHUNK:0]   slice;

        if (k == 0) begin : g_first
            assign sa = a[CHUNK-1:0];
            assign sb = b_eff[CHUNK-1:0];
            assign ci = c_eff;
            assign res_d[CHUNK-1:0] = slice[CHUNK-1:0];
            if (STAGES > 1) begin : g_fwd0
                assign opa_d[REM-1:0] = a[WIDTH-1:CHUNK];
                assign opb_d[REM-1:0] = b_eff[WIDTH-1:CHUNK];
            end
        end else begin : g_next
            localparam int PRO = CHUNK * (k - 1) * k / 2;
            localparam int POO = (k - 1) * WIDTH - PRO;
            assign sa = opa_q[POO +: CHUNK];
            assign sb = opb_q[POO +: CHUNK];
            assign ci = cy_q[k-1];
            assign res_d[RO +: (k+1)*CHUNK] = {slice[CHUNK-1:0], res_q[PRO +: k*CHUNK]};
            if (k < STAGES - 1) begin : g_fwd
                assign opa_d[OO +: REM] = opa_q[POO + CHUNK +: REM];
                assign opb_d[OO +: REM] = opb_q[POO + CHUNK +: REM];
            end
        end

        assign slice   = {1'b0, sa} + {1'b0, sb} + {{CHUNK{1'b0}}, ci};
        assign cy_d[k] = slice[CHUNK];

        // Carry into the MSB is a^b^sum at that bit; overflow when it differs from carry out.
        if (k == STAGES - 1) begin : g_last
            assign ovf_d = sa[CHUNK-1] ^ sb[CHUNK-1] ^ slice[CHUNK-1] ^ slice[CHUNK];
        end
    end

    if (STAGES == 1) begin : g_no_ops
        assign opa_d = '0;
        assign opb_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            cy_q  <= '0;
            res_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
            ovf_q <= 1'b0;
        end else if (en) begin
            v_q   <= v_d;
            cy_q  <= cy_d;
            res_q <= res_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = res_q[RES_W-1 -: WIDTH];
    assign c_out     = cy_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed corner cases, streaming, backpressure,
// mid-flight reset and a randomized sweep over several WIDTH/CHUNK configurations.
module tb_pipe_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, c_in, sub;
    logic        out_valid, out_ready, c_out, ovf;
    logic [15:0] a, b, sum;

    logic        sw_v, sw_r, sw_ci, sw_sub;
    logic [7:0]  a8, b8, s8;
    logic [31:0] a32, b32, s32;
    logic [3:0]  a4, b4, s4;
    logic        sw_ir [3];
    logic        sw_ov [3];
    logic        sw_co [3];
    logic        sw_of [3];

    logic [17:0] exp_q[$];
    logic [33:0] sw_hist [3][1000];
    int          n_checks;
    int          n_errors;

    logic [15:0] d_a   [6] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h0005, 16'h8000, 16'h8000};
    logic [15:0] d_b   [6] = '{16'h0001, 16'h0001, 16'h0007, 16'h0007, 16'h0001, 16'h0001};
    bit          d_ci  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bit          d_sub [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [17:0] d_exp [6] = '{{2'b01, 16'h0000}, {2'b10, 16'h8000}, {2'b00, 16'hFFFE},
                               {2'b00, 16'hFFFE}, {2'b11, 16'h7FFF}, {2'b11, 16'h7FFF}};

    pipe_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    pipe_adder #(.WIDTH(8), .CHUNK(4)) dut_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_v), .in_ready(sw_ir[0]),
        .a(a8), .b(b8), .c_in(sw_ci), .sub(sw_sub), .out_valid(sw_ov[0]),
        .out_ready(sw_r), .sum(s8), .c_out(sw_co[0]), .ovf(sw_of[0])
    );

    pipe_adder #(.WIDTH(32), .CHUNK(8)) dut_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_v), .in_ready(sw_ir[1]),
        .a(a32), .b(b32), .c_in(sw_ci), .sub(sw_sub), .out_valid(sw_ov[1]),
        .out_ready(sw_r), .sum(s32), .c_out(sw_co[1]), .ovf(sw_of[1])
    );

    pipe_adder #(.WIDTH(4), .CHUNK(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_v), .in_ready(sw_ir[2]),
        .a(a4), .b(b4), .c_in(sw_ci), .sub(sw_sub), .out_valid(sw_ov[2]),
        .out_ready(sw_r), .sum(s4), .c_out(sw_co[2]), .ovf(sw_of[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned result mod 2^w, carry/no-borrow from plain integer
    // comparison, overflow from the signed result leaving the w-bit range.
    function automatic logic [33:0] ref_op(input int w, input logic [31:0] x,
                                           input logic [31:0] y, input bit ci, input bit sb);
        longint one, modv, ux, uy, sx, sy, r, sr;
        bit co, ov;
        one  = 1;
        modv = one << w;
        ux   = {32'b0, x} & (modv - 1);
        uy   = {32'b0, y} & (modv - 1);
        sx   = (ux >= modv / 2) ? ux - modv : ux;
        sy   = (uy >= modv / 2) ? uy - modv : uy;
        if (sb) begin
            r  = ux - uy;
            co = (ux >= uy);
            sr = sx - sy;
        end else begin
            r  = ux + uy + longint'(ci);
            co = (r >= modv);
            sr = sx + sy + longint'(ci);
        end
        ov = (sr > modv / 2 - 1) || (sr < -(modv / 2));
        return {ov, co, 32'(r & (modv - 1))};
    endfunction

    function automatic logic [17:0] exp16(input logic [15:0] x, input logic [15:0] y,
                                          input bit ci, input bit sb);
        logic [33:0] m;
        m = ref_op(16, {16'b0, x}, {16'b0, y}, ci, sb);
        return {m[33], m[32], m[15:0]};
    endfunction

    task automatic drive_cycle(input bit v, input logic [15:0] aa, input logic [15:0] bb,
                               input bit ci, input bit sb, input bit rdy,
                               output bit acc, output bit cons, output logic [17:0] obs);
        @(negedge clk);
        in_valid  = v;
        a         = aa;
        b         = bb;
        c_in      = ci;
        sub       = sb;
        out_ready = rdy;
        #1;
        acc  = in_valid & in_ready;
        cons = out_valid & out_ready;
        obs  = {ovf, c_out, sum};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; c_in = 1'b0; sub = 1'b0;
        a = '0; b = '0;
        sw_v = 1'b0; sw_r = 1'b1; sw_ci = 1'b0; sw_sub = 1'b0;
        a8 = '0; b8 = '0; a32 = '0; b32 = '0; a4 = '0; b4 = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (sum !== 16'h0) begin n_errors++; $display("FAIL reset_sum: got %h expected 0000", sum); end
        n_checks++; if (c_out !== 1'b0) begin n_errors++; $display("FAIL reset_c_out: got %b expected 0", c_out); end
        n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        bit acc, cons;
        logic [17:0] obs, got;
        int lat;
        for (int t = 0; t < 6; t++) begin
            drive_cycle(1'b1, d_a[t], d_b[t], d_ci[t], d_sub[t], 1'b1, acc, cons, obs);
            n_checks++; if (!acc) begin n_errors++; $display("FAIL dir_accept[%0d]: got 0 expected 1", t); end
            lat = -1;
            got = '0;
            for (int i = 1; i <= 8; i++) begin
                drive_cycle(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                            1'b1, acc, cons, obs);
                if (cons && lat < 0) begin
                    lat = i;
                    got = obs;
                end
            end
            n_checks++; if (lat !== 4) begin n_errors++; $display("FAIL dir_latency[%0d]: got %0d expected 4", t, lat); end
            n_checks++; if (got !== d_exp[t]) begin n_errors++; $display("FAIL dir_result[%0d]: got %h expected %h", t, got, d_exp[t]); end
        end
    endtask

    task automatic test_back_to_back();
        bit acc, cons, pci;
        logic [17:0] obs, e;
        logic [15:0] pa, pb;
        int sent, got, first;
        sent = 0; got = 0; first = -1;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            pa = 16'($urandom); pb = 16'($urandom); pci = 1'($urandom);
            drive_cycle(sent < 8, pa, pb, pci, 1'b0, 1'b1, acc, cons, obs);
            if (acc) begin
                exp_q.push_back(exp16(pa, pb, pci, 1'b0));
                sent++;
            end
            if (cons) begin
                if (got == 0) first = cyc;
                n_checks++; if (cyc !== first + got) begin n_errors++; $display("FAIL b2b_gap: got cycle %0d expected %0d", cyc, first + got); end
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++; $display("FAIL b2b_unexpected: got %h expected none", obs);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL b2b_result[%0d]: got %h expected %h", got, obs, e); end
                end
                got++;
            end
        end
        n_checks++; if (got !== 8) begin n_errors++; $display("FAIL b2b_count: got %0d expected 8", got); end
    endtask

    task automatic test_backpressure();
        bit acc, cons, pci, psb, have, rdy, stalled_prev;
        logic [17:0] obs, e, held;
        logic [15:0] pa, pb;
        int sent, got, n_stall;
        sent = 0; got = 0; n_stall = 0; have = 1'b0; stalled_prev = 1'b0;
        pa = '0; pb = '0; pci = 1'b0; psb = 1'b0; held = '0;
        exp_q.delete();
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            if (!have && sent < 6) begin
                pa = 16'($urandom); pb = 16'($urandom); pci = 1'($urandom); psb = 1'($urandom);
                have = 1'b1;
            end
            rdy = !(cyc >= 5 && cyc < 8);
            drive_cycle(have, pa, pb, pci, psb, rdy, acc, cons, obs);
            if (!rdy && out_valid) begin
                n_stall++;
                n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
                if (stalled_prev) begin
                    n_checks++; if (obs !== held) begin n_errors++; $display("FAIL bp_hold: got %h expected %h", obs, held); end
                end
                held = obs;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (acc) begin
                exp_q.push_back(exp16(pa, pb, pci, psb));
                sent++;
                have = 1'b0;
            end
            if (cons) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++; $display("FAIL bp_unexpected: got %h expected none", obs);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL bp_result[%0d]: got %h expected %h", got, obs, e); end
                end
                got++;
            end
        end
        n_checks++; if (n_stall !== 3) begin n_errors++; $display("FAIL bp_stall_cycles: got %0d expected 3", n_stall); end
        n_checks++; if (got !== 6) begin n_errors++; $display("FAIL bp_count: got %0d expected 6", got); end
        n_checks++; if (exp_q.size() !== 0) begin n_errors++; $display("FAIL bp_leftover: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_random_flow();
        bit acc, cons, pci, psb, have;
        logic [17:0] obs, e;
        logic [15:0] pa, pb;
        have = 1'b0; pa = '0; pb = '0; pci = 1'b0; psb = 1'b0;
        exp_q.delete();
        for (int cyc = 0; cyc < 330; cyc++) begin
            if (!have && cyc < 300 && $urandom_range(0, 9) < 7) begin
                pa = 16'($urandom); pb = 16'($urandom); pci = 1'($urandom); psb = 1'($urandom);
                have = 1'b1;
            end
            drive_cycle(have, pa, pb, pci, psb, (cyc >= 300) || ($urandom_range(0, 9) < 7),
                        acc, cons, obs);
            if (acc) begin
                exp_q.push_back(exp16(pa, pb, pci, psb));
                have = 1'b0;
            end
            if (cons) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++; $display("FAIL rnd_unexpected: got %h expected none", obs);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL rnd_result: got %h expected %h", obs, e); end
                end
            end
        end
        n_checks++; if (exp_q.size() !== 0) begin n_errors++; $display("FAIL rnd_leftover: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_midflight();
        bit acc, cons;
        logic [17:0] obs;
        int stale;
        exp_q.delete();
        drive_cycle(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, acc, cons, obs);
        drive_cycle(1'b1, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, acc, cons, obs);
        for (int i = 0; i < 10 && !out_valid; i++) begin
            drive_cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, acc, cons, obs);
        end
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL mid_fill: got %b expected 1", out_valid); end
        n_checks++; if ({ovf, c_out, sum} !== exp16(16'h1234, 16'h4321, 1'b0, 1'b0)) begin
            n_errors++; $display("FAIL mid_head: got %h expected %h", {ovf, c_out, sum}, exp16(16'h1234, 16'h4321, 1'b0, 1'b0));
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
        n_checks++; if (sum !== 16'h0) begin n_errors++; $display("FAIL mid_rst_sum: got %h expected 0000", sum); end
        n_checks++; if (c_out !== 1'b0) begin n_errors++; $display("FAIL mid_rst_c_out: got %b expected 0", c_out); end
        n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL mid_rst_ovf: got %b expected 0", ovf); end
        @(posedge clk);
        #2 rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc, cons, obs);
            if (out_valid) stale++;
        end
        n_checks++; if (stale !== 0) begin n_errors++; $display("FAIL mid_stale: got %0d expected 0", stale); end
    endtask

    task automatic test_param_sweep();
        int w[3]  = '{8, 32, 4};
        int st[3] = '{2, 4, 1};
        logic [31:0] ra, rb;
        logic [33:0] got, e;
        bit exp_v;
        for (int c = 0; c < 1006; c++) begin
            @(negedge clk);
            ra = $urandom; rb = $urandom;
            sw_v = (c < 1000); sw_r = 1'b1;
            sw_ci = 1'($urandom); sw_sub = 1'($urandom);
            a8 = ra[7:0]; b8 = rb[7:0]; a32 = ra; b32 = rb; a4 = ra[3:0]; b4 = rb[3:0];
            #1;
            for (int d = 0; d < 3; d++) begin
                if (c < 1000) sw_hist[d][c] = ref_op(w[d], ra, rb, sw_ci, sw_sub);
                case (d)
                    0:       got = {sw_of[0], sw_co[0], 24'b0, s8};
                    1:       got = {sw_of[1], sw_co[1], s32};
                    default: got = {sw_of[2], sw_co[2], 28'b0, s4};
                endcase
                exp_v = (c - st[d] >= 0) && (c - st[d] < 1000);
                n_checks++; if (sw_ov[d] !== exp_v) begin n_errors++; $display("FAIL sweep_valid w%0d c%0d: got %b expected %b", w[d], c, sw_ov[d], exp_v); end
                if (exp_v) begin
                    e = sw_hist[d][c - st[d]];
                    n_checks++; if (got !== e) begin n_errors++; $display("FAIL sweep_result w%0d c%0d: got %h expected %h", w[d], c, got, e); end
                end
            end
        end
        sw_v = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random_flow();
        test_reset_midflight();
        test_param_sweep();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined ripple-carry adder/subtractor that adds one CHUNK-bit slice per pipeline stage, carrying between stages through registers instead of a combinational ripple chain. It is the next generation of our cascaded 4-bit full-adder adders. It adds a valid/ready handshake, backpressure, subtract mode and signed-overflow detection, and sits in front of the ALU/accumulator datapath wherever operands wider than one combinational ripple can close timing.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of CHUNK and at least CHUNK
- CHUNK, 4, bits added per stage; STAGES = WIDTH/CHUNK
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand bundle present
- in_ready  out  1  pipeline can accept this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- c_in  in  1  carry-in, used only when sub=0
- sub  in  1  1 = compute a - b, 0 = compute a + b + c_in
- out_valid  out  1  result bundle present
- out_ready  in  1  consumer accepts the result
- sum  out  WIDTH  result
- c_out  out  1  carry out of the MSB; in subtract mode 1 means no borrow
- ovf  out  1  signed (two's-complement) overflow

## Operation
- Effective operands: b_eff = sub ? ~b : b. Carry-in: sub ? 1 : c_in.
- Stage k (k = 0..STAGES-1) adds slice [k*CHUNK +: CHUNK] of a and b_eff plus the carry registered by stage k-1. Stage 0 uses the effective carry-in.
- Stage k registers the following:
  - result bits [(k+1)*CHUNK-1:0], with lower slices forwarded unchanged;
  - the slice carry-out;
  - a and b_eff upper slices not yet consumed;
  - one valid bit.
- Final stage:
  - c_out = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. This is computed within the last slice.
- Global stall: en = ~v[STAGES-1] | out_ready.
  - When en=1, every stage register loads from its predecessor. Stage 0 loads from the inputs, and v[0] takes in_valid.
  - When en=0, all stage registers hold.
- in_ready = en, combinational from out_ready and v[STAGES-1]. There is no combinational path from in_valid to in_ready.
- out_valid = v[STAGES-1]. sum, c_out and ovf come straight from the final-stage registers.
- Bubbles are not collapsed. An invalid slot advances like a valid one.
- Operand widths: all additions are done at CHUNK+1 bits per slice. No result bit is truncated except the final carry, which appears only on c_out.

## Timing
- Reset (rst_n low, asynchronous): all valid bits 0, out_valid=0, sum=0, c_out=0, ovf=0, all stage data registers 0.
  - in_ready is 1 while reset is active, because v is 0.
  - Release is synchronous to the first clk edge with rst_n high.
- Latency: an operand accepted at edge T (in_valid & in_ready) appears with out_valid=1 after edge T+STAGES-1. For example, at WIDTH=16, CHUNK=4 it is accepted at edge 0 and valid after edge 3, i.e. visible during cycle 4. This is 4 cycles.
- Throughput: one result per cycle while out_ready=1.
- A result is consumed at an edge where out_valid & out_ready. If out_ready=0 while out_valid=1, sum, c_out, ovf and out_valid hold stable until consumed.
- Simultaneous accept and consume in the same cycle is legal; the pipe shifts by one.
- If in_valid is asserted while in_ready=0, the operands are not captured. The source must hold them.
- Reset asserted mid-operation discards all in-flight results immediately. No partial result is ever presented.
- STAGES=1 degenerates to a single registered adder with latency 1.

## Test plan
- WIDTH=16, CHUNK=4, out_ready=1. Add 0xFFFF + 0x0001, c_in=0 → after 4 cycles sum=0x0000, c_out=1, ovf=0. Add 0x7FFF + 0x0001 → sum=0x8000, c_out=0, ovf=1.
- Subtract 0x0005 - 0x0007 → sum=0xFFFE, c_out=0, ovf=0. Subtract 0x8000 - 0x0001 → sum=0x7FFF, c_out=1, ovf=1. c_in is toggled during these and must have no effect.
- Back-to-back: 8 random pairs on consecutive cycles with out_ready=1 → 8 consecutive out_valid cycles with results in order, each matching a+b+c_in mod 2^16.
- Backpressure:
  - Stream 6 pairs and hold out_ready=0 for 3 cycles mid-stream → the output holds stable and in_ready=0 during the stall.
  - No result is lost or duplicated.
  - All 6 results match, in order.
- Reset mid-flight: accept 2 pairs, then pulse rst_n low between clock edges → out_valid, sum, c_out and ovf go to 0 immediately. After release, no stale result appears.
- Parameter sweep: WIDTH=8/CHUNK=4, WIDTH=32/CHUNK=8, WIDTH=4/CHUNK=4. Run 1000 random operations each against a reference model → all match, with latency equal to STAGES.
